stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Controller that owns the processor stack pointer and sequences all stack traffic to the data memory stack region (0xFF downward to 0xAF, 80 entries).
- Arbitrates two requesters: the core (single-byte PUSH/POP) and the interrupt unit (atomic two-byte entry push PC+flags / return pop flags+PC).
- Drives the data-memory stack port; replaces free-running combinational pointer update with a clocked, handshaked sequencer.

Parameters:
- SP_TOP, 8'hFF, reset/empty value of SP
- SP_BOTTOM, 8'hAF, full value of SP; no push allowed at this value
- DW, 8, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  core request, level, held until core_ack
- core_rw  in  1  0 = push, 1 = pop
- core_wdata  in  DW  push data
- core_ack  out  1  one-cycle completion pulse
- core_err  out  1  valid with core_ack; 1 = rejected (full/empty)
- core_rdata  out  DW  pop data, valid from core_ack until next core pop completes
- irq_req  in  1  interrupt-unit request, level, held until irq_ack
- irq_rw  in  1  0 = entry (push PC then flags), 1 = return (pop flags then PC)
- irq_pc, irq_flags  in  DW each  entry data
- irq_ack  out  1  one-cycle completion pulse
- irq_err  out  1  valid with irq_ack
- irq_rpc, irq_rflags  out  DW each  return data, held like core_rdata
- mem_addr  out  8  stack memory address
- mem_we  out  1  write strobe, data on mem_wdata this cycle
- mem_wdata  out  DW  write data
- mem_re  out  1  read strobe; mem_rdata valid next cycle
- mem_rdata  in  DW  read data (synchronous RAM, 1-cycle latency)
- sp  out  8  current stack pointer
- full, empty  out  1 each  sp==SP_BOTTOM, sp==SP_TOP
- max_depth  out  8  high-water mark (optional feature)

Behaviour:
- Reset (rst=1 at edge): sp=SP_TOP; state IDLE; all acks, errs, strobes 0; all rdata outputs 0; in-flight operation dropped without ack, requester must re-issue.
- Push byte: mem_addr=sp, mem_we=1, then sp<=sp-1 (post-decrement). Pop byte: mem_addr=sp+1, mem_re=1, sp<=sp+1, capture mem_rdata next cycle (pre-increment).
- States: IDLE, PUSH_A, PUSH_B, POP_A, CAP_A, POP_B, CAP_B, DONE.
- IDLE: irq_req has fixed priority over core_req when both high. Checks done in IDLE; on reject go straight to DONE with err=1, no memory access, sp unchanged.
- Core push: reject if full; else IDLE->PUSH_A->DONE. Ack 2 cycles after IDLE sample.
- Core pop: reject if empty; else IDLE->POP_A->CAP_A->DONE. Ack 3 cycles after.
- Irq entry: needs 2 free slots (sp-SP_BOTTOM>=2), else reject whole op. PUSH_A writes irq_pc, PUSH_B writes irq_flags, DONE.
- Irq return: needs 2 occupied (SP_TOP-sp>=2), else reject. POP_A/CAP_A -> irq_rflags, POP_B/CAP_B -> irq_rpc, DONE. Atomic; core cannot interleave.
- DONE: assert requester's ack (+err) one cycle, then IDLE. Requester drops req on the edge it sees ack; IDLE samples afresh next cycle.
- sp never leaves [SP_BOTTOM, SP_TOP]; no wrap-around.
- Request deasserted mid-operation: ignored; operation completes and acks.

Optional Feature:
- STACK_CTRL_DEPTH_TRACK_EN defined: max_depth register = max over time of (SP_TOP-sp), updated each cycle, reset to 0 by rst only.
- Undefined: no register, max_depth tied to 0.

Decomposition:
- Package stack_pkg: SP_TOP/SP_BOTTOM defaults, state enum, rw encodings (PUSH=0, POP=1, ENTRY=0, RETURN=1).
- One sub-module stack_sp_reg: sp register with sync reset, inc/dec enables, full/empty flags; controller FSM in stack_ctrl.

Test Plan:
- Reset then core push 0x5A -> mem_we at addr 0xFF, data 0x5A; core_ack 2 cycles later, err=0, sp=0xFE.
- Core pop after above -> mem_re addr 0xFF, core_rdata=0x5A, ack 3 cycles later, sp=0xFF, empty=1.
- Core pop at empty -> core_ack+core_err next DONE, no mem_re, sp stays 0xFF.
- 79 pushes (sp=0xB0), irq entry -> irq_err=1, no writes; one core push succeeds (sp=0xAF, full=1); next push -> err.
- core_req and irq_req same cycle, irq entry PC=0x12 flags=0x03 -> writes 0x12@sp, 0x03@sp-1 first, then core op; irq return yields irq_rflags=0x03, irq_rpc=0x12.
- rst asserted during PUSH_B -> no ack, sp=0xFF, strobes 0 next cycle; with STACK_CTRL_DEPTH_TRACK_EN max_depth=0.

Source files
------------

// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
//   Shared definitions for the stack controller slice.
//   - SP_TOP_DEF / SP_BOTTOM_DEF : default empty / full stack pointer values
//   - RW_* encodings for the core (PUSH/POP) and interrupt (ENTRY/RETURN) ports
//   - state_t : sequencer states
//   - owner_t : which requester owns the operation in flight
// -----------------------------------------------------------------------------
package stack_pkg;

  localparam logic [7:0] SP_TOP_DEF    = 8'hFF;
  localparam logic [7:0] SP_BOTTOM_DEF = 8'hAF;

  localparam logic RW_PUSH   = 1'b0;
  localparam logic RW_POP    = 1'b1;
  localparam logic RW_ENTRY  = 1'b0;
  localparam logic RW_RETURN = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH_A = 3'd1,
    PUSH_B = 3'd2,
    POP_A  = 3'd3,
    CAP_A  = 3'd4,
    POP_B  = 3'd5,
    CAP_B  = 3'd6,
    DONE   = 3'd7
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_IRQ  = 1'b1
  } owner_t;

endpackage

// File: rtl/stack_sp_reg.sv
// -----------------------------------------------------------------------------
// stack_sp_reg
//   Stack pointer register. Resets to SP_TOP, steps by one on inc/dec and
//   never leaves [SP_BOTTOM, SP_TOP] (a step past either bound is dropped).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   inc, dec     : single-cycle step requests (simultaneous = hold)
//   sp           : current stack pointer
//   full, empty  : sp == SP_BOTTOM, sp == SP_TOP
// -----------------------------------------------------------------------------
module stack_sp_reg
  import stack_pkg::*;
#(
  parameter logic [7:0] SP_TOP    = SP_TOP_DEF,
  parameter logic [7:0] SP_BOTTOM = SP_BOTTOM_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] sp,
  output logic       full,
  output logic       empty
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= SP_TOP;
    end else if (inc && !dec && (sp != SP_TOP)) begin
      sp <= sp + 8'd1;
    end else if (dec && !inc && (sp != SP_BOTTOM)) begin
      sp <= sp - 8'd1;
    end
  end

  assign full  = (sp == SP_BOTTOM);
  assign empty = (sp == SP_TOP);

endmodule

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
//   Owns the processor stack pointer and sequences all stack traffic to the
//   data-memory stack region (SP_TOP downward to SP_BOTTOM). Two requesters:
//   the core (single-byte PUSH/POP) and the interrupt unit (atomic two-byte
//   ENTRY push PC+flags / RETURN pop flags+PC). The interrupt unit wins when
//   both request in the same IDLE cycle. Push is post-decrement, pop is
//   pre-increment.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   core_req/rw/wdata            core request (level, held until core_ack)
//   core_ack/err/rdata           completion pulse, reject flag, pop data
//   irq_req/rw/pc/flags          interrupt-unit request and entry data
//   irq_ack/err/rpc/rflags       completion pulse, reject flag, return data
//   mem_addr/we/wdata/re         stack memory port (synchronous RAM)
//   mem_rdata                    read data, valid the cycle after mem_re
//   sp, full, empty              stack pointer and bound flags
//   max_depth                    high-water mark of SP_TOP - sp
//
// Build option:
//   STACK_CTRL_DEPTH_TRACK_EN    when defined, max_depth is a register holding
//                                the deepest stack seen since reset; otherwise
//                                max_depth is tied to zero.
// -----------------------------------------------------------------------------
module stack_ctrl
  import stack_pkg::*;
#(
  parameter logic [7:0] SP_TOP    = SP_TOP_DEF,
  parameter logic [7:0] SP_BOTTOM = SP_BOTTOM_DEF,
  parameter int         DW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_rw,
  input  logic [DW-1:0] core_wdata,
  output logic          core_ack,
  output logic          core_err,
  output logic [DW-1:0] core_rdata,
  input  logic          irq_req,
  input  logic          irq_rw,
  input  logic [DW-1:0] irq_pc,
  input  logic [DW-1:0] irq_flags,
  output logic          irq_ack,
  output logic          irq_err,
  output logic [DW-1:0] irq_rpc,
  output logic [DW-1:0] irq_rflags,
  output logic [7:0]    mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    sp,
  output logic          full,
  output logic          empty,
  output logic [7:0]    max_depth
);

  // Free slots below sp (pushes still allowed) and occupied entries above sp.
  function automatic logic [7:0] free_slots(input logic [7:0] p);
    return p - SP_BOTTOM;
  endfunction

  function automatic logic [7:0] used_slots(input logic [7:0] p);
    return SP_TOP - p;
  endfunction

  state_t          state, state_nx;
  owner_t          own;
  logic            op_err;
  logic [DW-1:0]   wd0, wd1;
  logic            sp_inc, sp_dec;

  logic            req_any;
  logic            req_irq;
  logic            req_rw;
  logic            reject;

  stack_sp_reg #(
    .SP_TOP    (SP_TOP),
    .SP_BOTTOM (SP_BOTTOM)
  ) u_sp (
    .clk   (clk),
    .rst   (rst),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  // Arbitration and admission checks, evaluated against the IDLE-cycle sp.
  // An interrupt op is rejected whole if both bytes cannot be moved.
  assign req_any = irq_req | core_req;
  assign req_irq = irq_req;
  assign req_rw  = irq_req ? irq_rw : core_rw;

  always_comb begin
    reject = 1'b0;
    if (req_irq) begin
      if (req_rw == RW_ENTRY) reject = (free_slots(sp) < 8'd2);
      else                    reject = (used_slots(sp) < 8'd2);
    end else begin
      if (req_rw == RW_PUSH)  reject = full;
      else                    reject = empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operation context is latched at the IDLE sample so a requester that
  // drops req or changes its data mid-operation has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      own    <= OWN_CORE;
      op_err <= 1'b0;
    end else if ((state == IDLE) && req_any) begin
      own    <= req_irq ? OWN_IRQ : OWN_CORE;
      op_err <= reject;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_any) begin
      wd0 <= req_irq ? irq_pc : core_wdata;
      wd1 <= irq_flags;
    end
  end

  // Read data is captured in the CAP_x cycle, one cycle after its mem_re.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rdata <= '0;
      irq_rflags <= '0;
      irq_rpc    <= '0;
    end else if (state == CAP_A) begin
      if (own == OWN_IRQ) irq_rflags <= mem_rdata;
      else                core_rdata <= mem_rdata;
    end else if (state == CAP_B) begin
      irq_rpc <= mem_rdata;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_addr  = sp;
    mem_we    = 1'b0;
    mem_wdata = wd0;
    mem_re    = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    core_ack  = 1'b0;
    core_err  = 1'b0;
    irq_ack   = 1'b0;
    irq_err   = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (reject)                 state_nx = DONE;
          else if (req_rw == RW_POP)  state_nx = POP_A;
          else                        state_nx = PUSH_A;
        end
      end
      PUSH_A: begin
        mem_we    = 1'b1;
        mem_wdata = wd0;
        sp_dec    = 1'b1;
        state_nx  = (own == OWN_IRQ) ? PUSH_B : DONE;
      end
      PUSH_B: begin
        mem_we    = 1'b1;
        mem_wdata = wd1;
        sp_dec    = 1'b1;
        state_nx  = DONE;
      end
      POP_A: begin
        mem_addr = sp + 8'd1;
        mem_re   = 1'b1;
        sp_inc   = 1'b1;
        state_nx = CAP_A;
      end
      CAP_A: begin
        state_nx = (own == OWN_IRQ) ? POP_B : DONE;
      end
      POP_B: begin
        mem_addr = sp + 8'd1;
        mem_re   = 1'b1;
        sp_inc   = 1'b1;
        state_nx = CAP_B;
      end
      CAP_B: begin
        state_nx = DONE;
      end
      DONE: begin
        if (own == OWN_IRQ) begin
          irq_ack = 1'b1;
          irq_err = op_err;
        end else begin
          core_ack = 1'b1;
          core_err = op_err;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef STACK_CTRL_DEPTH_TRACK_EN
  logic [7:0] max_depth_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_depth_q <= 8'd0;
    end else if (used_slots(sp) > max_depth_q) begin
      max_depth_q <= used_slots(sp);
    end
  end

  assign max_depth = max_depth_q;
`else
  assign max_depth = 8'd0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
//   Scoreboard bench for stack_ctrl. Drivers push the expected memory writes,
//   reads and completion responses into queues before raising a request; a
//   monitor on the falling edge pops and compares whenever the DUT strobes the
//   memory or acknowledges a requester.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;

  logic       clk;
  logic       rst;
  logic       core_req, core_rw;
  logic [7:0] core_wdata;
  logic       core_ack, core_err;
  logic [7:0] core_rdata;
  logic       irq_req, irq_rw;
  logic [7:0] irq_pc, irq_flags;
  logic       irq_ack, irq_err;
  logic [7:0] irq_rpc, irq_rflags;
  logic [7:0] mem_addr;
  logic       mem_we, mem_re;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] sp;
  logic       full, empty;
  logic [7:0] max_depth;

  stack_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_rw    (core_rw),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_err   (core_err),
    .core_rdata (core_rdata),
    .irq_req    (irq_req),
    .irq_rw     (irq_rw),
    .irq_pc     (irq_pc),
    .irq_flags  (irq_flags),
    .irq_ack    (irq_ack),
    .irq_err    (irq_err),
    .irq_rpc    (irq_rpc),
    .irq_rflags (irq_rflags),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .sp         (sp),
    .full       (full),
    .empty      (empty),
    .max_depth  (max_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    bit         irq;
    bit         err;
    bit         has_d;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] sp;
  } resp_t;

  resp_t       rq[$];
  logic [15:0] wq[$];
  logic [7:0]  raq[$];

  int checks = 0;
  int passes = 0;

  // Reference stack: pointer plus byte image of the stack region.
  logic [7:0] msp;
  logic [7:0] smem [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  resp_t       mr;
  logic [15:0] mw;
  logic [7:0]  ma;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      chk("write_expected", (wq.size() != 0), 1);
      if (wq.size() != 0) begin
        mw = wq.pop_front();
        chk("wr_addr", mem_addr, mw[15:8]);
        chk("wr_data", mem_wdata, mw[7:0]);
      end
    end
    if (mem_re === 1'b1) begin
      chk("read_expected", (raq.size() != 0), 1);
      if (raq.size() != 0) begin
        ma = raq.pop_front();
        chk("rd_addr", mem_addr, ma);
      end
    end
    if ((core_ack === 1'b1) || (irq_ack === 1'b1)) begin
      chk("ack_expected", (rq.size() != 0), 1);
      if (rq.size() != 0) begin
        mr = rq.pop_front();
        chk("ack_owner_irq", irq_ack, mr.irq);
        chk("ack_owner_core", core_ack, !mr.irq);
        chk("ack_err", mr.irq ? irq_err : core_err, mr.err);
        chk("ack_sp", sp, mr.sp);
        chk("ack_full", full, (mr.sp == 8'hAF));
        chk("ack_empty", empty, (mr.sp == 8'hFF));
        if (mr.has_d) begin
          if (mr.irq) begin
            chk("irq_rflags", irq_rflags, mr.d0);
            chk("irq_rpc", irq_rpc, mr.d1);
          end else begin
            chk("core_rdata", core_rdata, mr.d0);
          end
        end
      end
    end
  end

  // ---------------- expectation builders ----------------
  task automatic exp_core(input bit rw, input logic [7:0] d, output int lat);
    if (rw == 1'b0) begin
      if (msp == 8'hAF) begin
        rq.push_back('{irq: 0, err: 1, has_d: 0, d0: 0, d1: 0, sp: msp});
        lat = 1;
      end else begin
        wq.push_back({msp, d});
        smem[msp] = d;
        msp = msp - 8'd1;
        rq.push_back('{irq: 0, err: 0, has_d: 0, d0: 0, d1: 0, sp: msp});
        lat = 2;
      end
    end else begin
      if (msp == 8'hFF) begin
        rq.push_back('{irq: 0, err: 1, has_d: 0, d0: 0, d1: 0, sp: msp});
        lat = 1;
      end else begin
        msp = msp + 8'd1;
        raq.push_back(msp);
        rq.push_back('{irq: 0, err: 0, has_d: 1, d0: smem[msp], d1: 0, sp: msp});
        lat = 3;
      end
    end
  endtask

  task automatic exp_irq(input bit rw, input logic [7:0] pc, input logic [7:0] fl,
                         output int lat);
    logic [7:0] f, p;
    if (rw == 1'b0) begin
      if ((msp - 8'hAF) < 8'd2) begin
        rq.push_back('{irq: 1, err: 1, has_d: 0, d0: 0, d1: 0, sp: msp});
        lat = 1;
      end else begin
        wq.push_back({msp, pc});
        smem[msp] = pc;
        msp = msp - 8'd1;
        wq.push_back({msp, fl});
        smem[msp] = fl;
        msp = msp - 8'd1;
        rq.push_back('{irq: 1, err: 0, has_d: 0, d0: 0, d1: 0, sp: msp});
        lat = 3;
      end
    end else begin
      if ((8'hFF - msp) < 8'd2) begin
        rq.push_back('{irq: 1, err: 1, has_d: 0, d0: 0, d1: 0, sp: msp});
        lat = 1;
      end else begin
        msp = msp + 8'd1;
        raq.push_back(msp);
        f = smem[msp];
        msp = msp + 8'd1;
        raq.push_back(msp);
        p = smem[msp];
        rq.push_back('{irq: 1, err: 0, has_d: 1, d0: f, d1: p, sp: msp});
        lat = 5;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_core(input bit rw, input logic [7:0] d, input int lat);
    int n = 0;
    core_req = 1'b1; core_rw = rw; core_wdata = d;
    while (n < 60) begin
      @(posedge clk); #1; n++;
      if (core_ack) break;
    end
    chk("core_ack_seen", core_ack, 1);
    if (lat >= 0) chk("core_latency", n, lat);
    core_req = 1'b0;
  endtask

  task automatic do_irq(input bit rw, input logic [7:0] pc, input logic [7:0] fl,
                        input int lat);
    int n = 0;
    irq_req = 1'b1; irq_rw = rw; irq_pc = pc; irq_flags = fl;
    while (n < 60) begin
      @(posedge clk); #1; n++;
      if (irq_ack) break;
    end
    chk("irq_ack_seen", irq_ack, 1);
    if (lat >= 0) chk("irq_latency", n, lat);
    irq_req = 1'b0;
  endtask

  // One cycle for the DUT to leave DONE before the next request.
  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic core_op(input bit rw, input logic [7:0] d);
    int lat;
    exp_core(rw, d, lat);
    do_core(rw, d, lat);
    gap();
  endtask

  task automatic irq_op(input bit rw, input logic [7:0] pc, input logic [7:0] fl);
    int lat;
    exp_irq(rw, pc, fl, lat);
    do_irq(rw, pc, fl, lat);
    gap();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat_i, lat_c;
    rst = 1'b1;
    core_req = 1'b0; core_rw = 1'b0; core_wdata = 8'h00;
    irq_req = 1'b0; irq_rw = 1'b0; irq_pc = 8'h00; irq_flags = 8'h00;
    msp = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_sp", sp, 8'hFF);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_core_ack", core_ack, 0);
    chk("reset_irq_ack", irq_ack, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_re", mem_re, 0);
    chk("reset_core_rdata", core_rdata, 8'h00);
    chk("reset_irq_rpc", irq_rpc, 8'h00);
    chk("reset_max_depth", max_depth, 8'h00);

    // Single push then pop of 0x5A.
    core_op(1'b0, 8'h5A);
    chk("push_sp", sp, 8'hFE);
    irq_op(1'b1, 8'h00, 8'h00);            // only one entry: return rejected
    core_op(1'b1, 8'h00);
    chk("pop_rdata", core_rdata, 8'h5A);
    chk("pop_empty", empty, 1);
    core_op(1'b1, 8'h00);                  // pop at empty: rejected
    chk("empty_pop_sp", sp, 8'hFF);

    // Simultaneous requests: irq entry must complete before the core push.
    exp_irq(1'b0, 8'h12, 8'h03, lat_i);
    exp_core(1'b0, 8'h77, lat_c);
    fork
      do_irq(1'b0, 8'h12, 8'h03, lat_i);
      do_core(1'b0, 8'h77, -1);
    join
    gap();
    chk("both_sp", sp, 8'hFC);
    core_op(1'b1, 8'h00);
    chk("pop77_rdata", core_rdata, 8'h77);
    irq_op(1'b1, 8'h00, 8'h00);
    chk("ret_rflags", irq_rflags, 8'h03);
    chk("ret_rpc", irq_rpc, 8'h12);

    // Reset while the second byte of an entry is being written.
    wq.push_back({8'hFF, 8'h34});
    wq.push_back({8'hFE, 8'h56});
    smem[8'hFF] = 8'h34;
    smem[8'hFE] = 8'h56;
    irq_req = 1'b1; irq_rw = 1'b0; irq_pc = 8'h34; irq_flags = 8'h56;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pushb_we", mem_we, 1);
    chk("pushb_addr", mem_addr, 8'hFE);
    rst = 1'b1;
    irq_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    msp = 8'hFF;
    chk("midrst_sp", sp, 8'hFF);
    chk("midrst_we", mem_we, 0);
    chk("midrst_re", mem_re, 0);
    chk("midrst_irq_ack", irq_ack, 0);
    chk("midrst_rflags", irq_rflags, 8'h00);
    chk("midrst_max_depth", max_depth, 8'h00);
    repeat (4) @(posedge clk);
    #1;

    // Fill to one slot above full, then exercise the bounds.
    for (int i = 0; i < 79; i++) core_op(1'b0, 8'(i + 1));
    chk("fill_sp", sp, 8'hB0);
    irq_op(1'b0, 8'hAA, 8'hBB);            // one free slot: entry rejected
    chk("fill_entry_sp", sp, 8'hB0);
    core_op(1'b0, 8'hCC);
    chk("full_sp", sp, 8'hAF);
    chk("full_flag", full, 1);
    core_op(1'b0, 8'hDD);                  // rejected at full
`ifdef STACK_CTRL_DEPTH_TRACK_EN
    chk("max_depth_full", max_depth, 8'h50);
`else
    chk("max_depth_off", max_depth, 8'h00);
`endif
    core_op(1'b1, 8'h00);
    chk("pop_cc", core_rdata, 8'hCC);
    irq_op(1'b1, 8'h00, 8'h00);            // pops 0x4F (flags) then 0x4E (pc)
    chk("ret_fill_rflags", irq_rflags, 8'h4F);
    chk("ret_fill_rpc", irq_rpc, 8'h4E);

    repeat (5) @(posedge clk);
    #1;
    chk("resp_q_drained", rq.size(), 0);
    chk("write_q_drained", wq.size(), 0);
    chk("read_q_drained", raq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
